// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    typedef logic [0:0] port_id_t;

    // One bit wider than an address so the end-of-word compare cannot wrap.
    typedef logic [WORD_W:0] addr_ext_t;

    // Word access is legal when aligned and the whole word lies inside memory.
    function automatic logic addr_legal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       mem_bytes);
        addr_ext_t end_excl;
        end_excl = {1'b0, addr} + addr_ext_t'(4);
        return (addr[1:0] == 2'b00) && (end_excl <= addr_ext_t'(mem_bytes));
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way request picker: round-robin on conflict, or port 0 first when fixed.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t rr_last,
    input  logic     fixed,
    output logic     valid,
    output port_id_t id
);

    // A lone requester always wins; on conflict the port not served last wins.
    always_comb begin
        valid = req0 | req1;
        id    = 1'b0;
        if (req0 && req1) begin
            id = fixed ? 1'b0 : ~rr_last;
        end else if (req1) begin
            id = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU port (0) and the
// loader/debug port (1). One access per grant cycle, read data one cycle later.
// Optional build macro: DMEM_ARB_STATS_EN adds conflict/error counters.
//
// state | meaning
// IDLE  | nothing latched; watching req0/req1 for a winner
// SERVE | latched access is on the memory pins, gnt asserted for its port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 128,
    parameter bit          PRIO0_FIXED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [WORD_W-1:0] addr0,
    input  logic [WORD_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_writeData,
    output logic              mem_writeMem,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       err_cnt,
`endif
    input  logic [WORD_W-1:0] mem_data
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SERVE = SERVE;

    logic [0:0]        state_q, state_d;
    port_id_t          lat_id_q, lat_id_d;
    logic              lat_we_q, lat_we_d;
    logic [WORD_W-1:0] lat_addr_q, lat_addr_d;
    logic [WORD_W-1:0] lat_wdata_q, lat_wdata_d;
    port_id_t          rr_last_q, rr_last_d;

    logic              rvalid0_q, rvalid1_q;
    logic              err0_q, err1_q;
    logic [WORD_W-1:0] rdata0_q, rdata1_q;
    logic [WORD_W-1:0] ret_data_d;

    logic              pick_valid;
    port_id_t          pick_id;
    logic              pick_conflict;
    logic              serving;
    logic              serve0, serve1;
    logic              lat_legal;

    rr_pick2 u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last_q),
        .fixed   (PRIO0_FIXED),
        .valid   (pick_valid),
        .id      (pick_id)
    );

    assign pick_conflict = req0 & req1;

    // A reset cycle must never drive a grant or a memory write, even from SERVE.
    assign serving   = (state_q == ST_SERVE) && !reset;
    assign serve0    = serving && (lat_id_q == 1'b0);
    assign serve1    = serving && (lat_id_q == 1'b1);
    assign lat_legal = addr_legal(lat_addr_q, MEM_BYTES);

    // Next winner is taken from the same sampling in IDLE and SERVE, which is
    // what lets a port that keeps req high get back-to-back grants.
    always_comb begin
        state_d     = ST_IDLE;
        lat_id_d    = lat_id_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rr_last_d   = rr_last_q;
        if (pick_valid) begin
            state_d     = ST_SERVE;
            lat_id_d    = pick_id;
            lat_we_d    = (pick_id == 1'b1) ? we1 : we0;
            lat_addr_d  = (pick_id == 1'b1) ? addr1 : addr0;
            lat_wdata_d = (pick_id == 1'b1) ? wdata1 : wdata0;
            rr_last_d   = pick_id;
        end
    end

    // FSM and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_id_q    <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            lat_id_q    <= lat_id_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rr_last_q   <= rr_last_d;
        end
    end

    // Illegal accesses return zero instead of whatever the memory drives.
    assign ret_data_d = lat_legal ? mem_data : '0;

    // Return path: rvalid/err pulse one cycle after the grant, rdata holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= serve0;
            rvalid1_q <= serve1;
            err0_q    <= serve0 && !lat_legal;
            err1_q    <= serve1 && !lat_legal;
            if (serve0) begin
                rdata0_q <= ret_data_d;
            end
            if (serve1) begin
                rdata1_q <= ret_data_d;
            end
        end
    end

    assign gnt0          = serve0;
    assign gnt1          = serve1;
    assign rvalid0       = rvalid0_q;
    assign rvalid1       = rvalid1_q;
    assign err0          = err0_q;
    assign err1          = err1_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign mem_addr      = serving ? lat_addr_q : '0;
    assign mem_writeData = serving ? lat_wdata_q : '0;
    assign mem_writeMem  = serving && lat_we_q && lat_legal;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters of arbitration conflicts and illegal accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            if (pick_conflict && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
            if (serving && !lat_legal && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign err_cnt      = err_cnt_q;
`else
    logic unused_conflict;
    assign unused_conflict = pick_conflict;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_writeMem;
    logic [31:0] rdata0, rdata1, mem_addr, mem_writeData, mem_data;
    logic        fx_gnt0, fx_gnt1, fx_rvalid0, fx_rvalid1, fx_err0, fx_err1, fx_mem_writeMem;
    logic [31:0] fx_rdata0, fx_rdata1, fx_mem_addr, fx_mem_writeData, fx_mem_data;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt, err_cnt, fx_conflict_cnt, fx_err_cnt;
`endif

    dmem_arbiter dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_writeData(mem_writeData), .mem_writeMem(mem_writeMem),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .err_cnt(err_cnt),
`endif
        .mem_data(mem_data)
    );

    dmem_arbiter #(.PRIO0_FIXED(1'b1)) dut_fx (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(fx_gnt0), .gnt1(fx_gnt1), .rvalid0(fx_rvalid0), .rvalid1(fx_rvalid1),
        .rdata0(fx_rdata0), .rdata1(fx_rdata1), .err0(fx_err0), .err1(fx_err1),
        .mem_addr(fx_mem_addr), .mem_writeData(fx_mem_writeData), .mem_writeMem(fx_mem_writeMem),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt(fx_conflict_cnt), .err_cnt(fx_err_cnt),
`endif
        .mem_data(fx_mem_data)
    );

    // Data memory driven by the main instance; the fixed-priority copy only reads it.
    logic [31:0] mem [32];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_writeMem && (mem_addr < 32'd128)) begin
            mem[mem_addr[6:2]] <= mem_writeData;
        end
    end
    assign mem_data    = (mem_addr < 32'd128) ? mem[mem_addr[6:2]] : 32'h0BAD_0BAD;
    assign fx_mem_data = (fx_mem_addr < 32'd128) ? mem[fx_mem_addr[6:2]] : 32'h0BAD_0BAD;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One isolated access from IDLE: req in N, gnt in N+1, rvalid in N+2.
    task automatic do_single(input int p, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic exp_err,
                             input logic [31:0] exp_rd, input string nm);
        @(posedge clk); #1;
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
        @(negedge clk);
        chk({nm, "_idle_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        chk({nm, "_gnt"}, {30'd0, gnt1, gnt0}, (p == 0) ? 32'd1 : 32'd2);
        chk({nm, "_wmem"}, {31'd0, mem_writeMem}, {31'd0, we & ~exp_err});
        if (!exp_err) chk({nm, "_maddr"}, mem_addr, a);
        if (!exp_err && we) chk({nm, "_mwdata"}, mem_writeData, wd);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_rvalid"}, {30'd0, rvalid1, rvalid0}, (p == 0) ? 32'd1 : 32'd2);
        chk({nm, "_err"}, {31'd0, (p == 0) ? err0 : err1}, {31'd0, exp_err});
        chk({nm, "_rdata"}, (p == 0) ? rdata0 : rdata1, exp_rd);
        chk({nm, "_gnt_done"}, {30'd0, gnt1, gnt0}, 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    // Reference model for the random phase.
    logic [31:0] ref_mem [32];
    logic        t_req [2];
    logic        t_we  [2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wd  [2];

    function automatic bit model_legal(input logic [31:0] a);
        longint la;
        la = longint'({32'd0, a});
        return ((la % 4) == 0) && ((la + 4) <= 128);
    endfunction

    task automatic new_txn(input int p);
        logic [31:0] a;
        case ($urandom_range(0, 9))
            7:       a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            8:       a = 32'd128 + 32'($urandom_range(0, 32)) * 4;
            9:       a = $urandom | 32'h8000_0000;
            default: a = 32'($urandom_range(0, 31)) * 4;
        endcase
        t_req[p] = 1'b1; t_we[p] = 1'($urandom_range(0, 1)); t_addr[p] = a; t_wd[p] = $urandom;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [3:0]  rr_order;
        int          exp_g_cur, exp_g_next, last;
        logic        rv_cur[2], rv_next[2], er_cur[2], er_next[2];
        logic [31:0] rd_cur[2], rd_next[2], rd_hold[2];
        logic        exp_wm;
        logic [31:0] exp_maddr, exp_mwd;
        logic        g_act, rv_act, er_act;
        logic [31:0] rd_act;
        bit          lg;

        reset = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("rst_gnt",    {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_err",    {30'd0, err1, err0}, 32'd0);
        chk("rst_wmem",   {31'd0, mem_writeMem}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_maddr",  mem_addr, 32'd0);
        chk("rst_mwdata", mem_writeData, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // memory starts as mem[i] = 0x1000_0000 + i
        vecs.push_back('{0, 1'b1, 32'd8,          32'hDEAD_BEEF, 1'b0, 32'h1000_0002});
        vecs.push_back('{1, 1'b0, 32'd8,          32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b1, 32'd6,          32'h1234_5678, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd124,        32'h0,         1'b0, 32'h1000_001F});
        vecs.push_back('{1, 1'b0, 32'd128,        32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'd4,          32'h0,         1'b0, 32'h1000_0001});
        vecs.push_back('{1, 1'b1, 32'd124,        32'hCAFE_F00D, 1'b0, 32'h1000_001F});
        vecs.push_back('{0, 1'b0, 32'd124,        32'h0,         1'b0, 32'hCAFE_F00D});
        vecs.push_back('{1, 1'b1, 32'hFFFF_FFFC,  32'h7777_7777, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd1,          32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'd8,          32'h0,         1'b0, 32'hDEAD_BEEF});
        foreach (vecs[i])
            do_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

        // Both ports held: round-robin 0,1,0,1; fixed priority serves port 0 only.
        apply_reset();
        rr_order = 4'b1010;
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd4; wdata0 = '0; wdata1 = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
            chk($sformatf("rr_gnt_k%0d", k), {30'd0, gnt1, gnt0}, rr_order[k] ? 32'd2 : 32'd1);
            chk($sformatf("fx_gnt_k%0d", k), {30'd0, fx_gnt1, fx_gnt0}, 32'd1);
            chk($sformatf("fx_rvalid0_k%0d", k), {31'd0, fx_rvalid0}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk($sformatf("rr_rvalid_k%0d", k), {30'd0, rvalid1, rvalid0},
                    rr_order[k-1] ? 32'd2 : 32'd1);
                chk($sformatf("rr_rdata_k%0d", k), rr_order[k-1] ? rdata1 : rdata0,
                    rr_order[k-1] ? 32'h1000_0001 : 32'h1000_0000);
                chk($sformatf("fx_rdata0_k%0d", k), fx_rdata0, 32'h1000_0000);
            end
            chk($sformatf("fx_misc_k%0d", k),
                {27'd0, fx_rvalid1, fx_err1, fx_err0, fx_mem_writeMem, 1'b0}, 32'd0);
            chk($sformatf("fx_maddr_k%0d", k), fx_mem_addr | fx_mem_writeData | fx_rdata1, 32'd0);
        end
        repeat (3) @(posedge clk);

        // Back-to-back reads on port 0 with req held across the first gnt.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
        @(negedge clk);
        chk("b2b_idle", {31'd0, gnt0}, 32'd0);
        @(posedge clk); #1 addr0 = 32'd4;
        @(negedge clk);
        chk("b2b_gnt_a", {31'd0, gnt0}, 32'd1);
        chk("b2b_maddr_a", mem_addr, 32'd0);
        chk("b2b_rv_a", {31'd0, rvalid0}, 32'd0);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("b2b_gnt_b", {31'd0, gnt0}, 32'd1);
        chk("b2b_maddr_b", mem_addr, 32'd4);
        chk("b2b_rv_b", {31'd0, rvalid0}, 32'd1);
        chk("b2b_rd_b", rdata0, 32'h1000_0000);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gnt_c", {31'd0, gnt0}, 32'd0);
        chk("b2b_rv_c", {31'd0, rvalid0}, 32'd1);
        chk("b2b_rd_c", rdata0, 32'h1000_0001);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rv_d", {31'd0, rvalid0}, 32'd0);
        chk("b2b_hold", rdata0, 32'h1000_0001);

        // Reset landing on the SERVE cycle of a write.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'h55AA_55AA;
        @(posedge clk); #1;
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("rstmid_wmem", {31'd0, mem_writeMem}, 32'd0);
        chk("rstmid_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_rv", {28'd0, err1, err0, rvalid1, rvalid0}, 32'd0);
        chk("rstmid_rdata0", rdata0, 32'd0);
        chk("rstmid_gnt2", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rstmid_maddr", mem_addr, 32'd0);
        do_single(1, 1'b0, 32'd12, 32'd0, 1'b0, 32'h1000_0003, "rstmid_readback");

`ifdef DMEM_ARB_STATS_EN
        apply_reset();
        @(negedge clk);
        chk("stat_rst_cc", {16'd0, conflict_cnt}, 32'd0);
        chk("stat_rst_ec", {16'd0, err_cnt}, 32'd0);
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd0; addr1 = 32'd4;
        repeat (3) @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        do_single(0, 1'b1, 32'd6, 32'd0, 1'b1, 32'd0, "stat_ill0");
        do_single(1, 1'b0, 32'd128, 32'd0, 1'b1, 32'd0, "stat_ill1");
        chk("stat_cc", {16'd0, conflict_cnt}, 32'd3);
        chk("stat_ec", {16'd0, err_cnt}, 32'd2);
        chk("stat_fx_cc", {16'd0, fx_conflict_cnt}, 32'd3);
        chk("stat_fx_ec", {16'd0, fx_err_cnt}, 32'd2);
        apply_reset();
        @(negedge clk);
        chk("stat_clr_cc", {16'd0, conflict_cnt}, 32'd0);
        chk("stat_clr_ec", {16'd0, err_cnt}, 32'd0);
`endif

        // Randomized traffic against the transaction-level model.
        apply_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            t_req[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_wd[p] = '0;
            rv_next[p] = 1'b0; er_next[p] = 1'b0; rd_next[p] = '0; rd_hold[p] = '0;
        end
        exp_g_next = -1;
        last = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            exp_g_cur = exp_g_next;
            rv_cur = rv_next; er_cur = er_next; rd_cur = rd_next;
            rv_next[0] = 1'b0; rv_next[1] = 1'b0;
            exp_wm = 1'b0; exp_maddr = '0; exp_mwd = '0;
            for (int p = 0; p < 2; p++) begin
                if (exp_g_cur == p) begin
                    lg = model_legal(t_addr[p]);
                    rv_next[p] = 1'b1;
                    er_next[p] = !lg;
                    rd_next[p] = lg ? ref_mem[t_addr[p][6:2]] : 32'd0;
                    exp_wm = t_we[p] && lg;
                    exp_maddr = t_addr[p];
                    exp_mwd = t_wd[p];
                    if (exp_wm) ref_mem[t_addr[p][6:2]] = t_wd[p];
                    if ($urandom_range(0, 2) == 0) new_txn(p);
                    else t_req[p] = 1'b0;
                end else if (!t_req[p] && ($urandom_range(0, 2) == 0)) begin
                    new_txn(p);
                end
            end
            req0 = t_req[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wd[0];
            req1 = t_req[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wd[1];
            if (t_req[0] && t_req[1]) exp_g_next = (last == 0) ? 1 : 0;
            else if (t_req[0])        exp_g_next = 0;
            else if (t_req[1])        exp_g_next = 1;
            else                      exp_g_next = -1;
            if (exp_g_next >= 0) last = exp_g_next;

            @(negedge clk);
            chk("rnd_wmem", {31'd0, mem_writeMem}, {31'd0, exp_wm});
            if (exp_g_cur >= 0) begin
                chk("rnd_maddr", mem_addr, exp_maddr);
                chk("rnd_mwdata", mem_writeData, exp_mwd);
            end
            for (int p = 0; p < 2; p++) begin
                g_act  = (p == 0) ? gnt0 : gnt1;
                rv_act = (p == 0) ? rvalid0 : rvalid1;
                er_act = (p == 0) ? err0 : err1;
                rd_act = (p == 0) ? rdata0 : rdata1;
                if (rv_cur[p]) rd_hold[p] = rd_cur[p];
                chk($sformatf("rnd_gnt%0d_c%0d", p, cyc), {31'd0, g_act}, (exp_g_cur == p) ? 32'd1 : 32'd0);
                chk($sformatf("rnd_rvalid%0d_c%0d", p, cyc), {31'd0, rv_act}, {31'd0, rv_cur[p]});
                chk($sformatf("rnd_err%0d_c%0d", p, cyc), {31'd0, er_act}, {31'd0, rv_cur[p] & er_cur[p]});
                chk($sformatf("rnd_rdata%0d_c%0d", p, cyc), rd_act, rd_hold[p]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
